regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the single-issue CPU register file.
- Generalised data width, register count and read-port count.
- Adds hardwired-zero x0, async reset clearing of all state, write-through bypass to the read ports, and a per-register pending-write scoreboard with a stall output for the pipelined core.
- Sits between decode (read ports and issue marking) and writeback (write port and clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, ≥2)
AW, 5, register address width, equal to log2(NREGS)
NREAD, 2, number of independent read ports
DBG_REG, 10, index driven onto dbg_out (a0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
we  in  1  write enable
waddr  in  AW  write register address
wdata  in  XLEN  write data
wb_clr  in  1  qualifies we: this write retires a pending op; clear busy[waddr]
iss_vld  in  1  issue of long-latency op targeting iss_rd
iss_rd  in  AW  destination register to mark busy
raddr  in  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW]
rdata  out  NREAD*XLEN  packed read data
rbusy  out  NREAD  port i source is pending
stall  out  1  OR of rbusy
busy_cnt  out  AW+1  number of registers currently busy, registered
dbg_out  out  XLEN  architectural content of register DBG_REG

Behaviour:
- Reset:
  - One clock domain, clk. Reset is asynchronous and active-low.
  - On rst_n=0: all registers = 0, all busy bits = 0, busy_cnt = 0.
  - Outputs therefore read rdata = 0, rbusy = 0, stall = 0, dbg_out = 0.
  - Reset asserted mid-operation discards any in-flight write or issue in that cycle.
- Write:
  - On a rising edge with we=1 and waddr≠0: reg[waddr] ← wdata.
  - Writes to x0 are ignored. Register 0 always reads 0.
- Read (combinational, zero latency), per port i:
  - raddr_i = 0 → rdata_i = 0.
  - Else if we=1 and waddr = raddr_i → rdata_i = wdata (write-through bypass).
  - Else rdata_i = reg[raddr_i].
- dbg_out: architectural value reg[DBG_REG] only, no bypass. Updates the cycle after the write.
- Scoreboard (one busy bit per register, bit 0 tied to 0):
  - Set: iss_vld=1 and iss_rd≠0 → busy[iss_rd] ← 1 on the clock edge.
  - Clear: we=1 and wb_clr=1 and waddr≠0 → busy[waddr] ← 0.
  - Same register set and cleared in one cycle: set wins (the new issue is younger). Busy stays 1; busy_cnt unchanged.
  - Set of an already-busy register: no change, no count change.
  - Clear of a non-busy register: no change, no count underflow.
  - we=1 with wb_clr=0 writes data but leaves busy untouched.
- rbusy_i = busy[raddr_i] AND NOT (we AND wb_clr AND waddr = raddr_i).
  - A source retiring this cycle is forwarded by the bypass, not stalled.
  - raddr_i = 0 → rbusy_i = 0.
- stall = |rbusy, combinational.
- busy_cnt:
  - Registered; equals the popcount of busy after the edge.
  - Updated incrementally: +1 for an effective set, −1 for an effective clear, net 0 if both hit different registers.
  - Range 0..NREGS−1, no wrap.
- No X on any output after reset for any input combination.

Test Plan:
- Reset, then read all ports at addresses 0, 5, 31 → rdata = 0, stall = 0, busy_cnt = 0. Assert rst_n low mid-write of x5 = 0xDEADBEEF → x5 still 0 after release.
- Write x0 = 0xFFFFFFFF, then read x0 on all ports → 0. busy set on x0 via iss_vld → busy_cnt stays 0.
- Bypass: in the same cycle we=1, waddr=7, wdata=0x12345678 with raddr0=7 → rdata0 = 0x12345678 that cycle. dbg_out for waddr=10, wdata=0xA5 → 0xA5 one cycle later, not the same cycle.
- Scoreboard: issue x3 → next cycle raddr1=3 gives rbusy1 = 1, stall = 1, busy_cnt = 1. Writeback x3 with wb_clr=1, wdata=0x55 and raddr1=3 → same cycle rbusy1 = 0, rdata1 = 0x55; then busy_cnt = 0.
- Simultaneous events on x9: issue and clear of x9 in one cycle → busy stays 1, busy_cnt unchanged. Issue x4 plus clear x9 → busy_cnt net unchanged. Clear of idle x12 → busy_cnt unchanged, no underflow.
- Fill: issue x1..x31 on consecutive cycles → busy_cnt = 31. Re-issue x1 → stays 31. Then clear all → 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired-zero x0, write-through bypass and a
// per-register pending-write scoreboard that raises stall for the pipelined core.
module regfile_sb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned DBG_REG = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  wb_clr,
  input  logic                  iss_vld,
  input  logic [AW-1:0]         iss_rd,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  output logic                  stall,
  output logic [AW:0]           busy_cnt,
  output logic [XLEN-1:0]       dbg_out
);

  localparam logic [AW-1:0] DbgIdx = AW'(DBG_REG);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;

  logic             w_wr;
  logic             w_set;
  logic             w_clr;
  logic             w_set_eff;
  logic             w_clr_eff;
  logic [NREGS-1:0] w_busy_d;
  logic [AW:0]      w_cnt_d;

  assign w_wr  = we && (waddr != '0);
  assign w_set = iss_vld && (iss_rd != '0);
  assign w_clr = w_wr && wb_clr;

  // A set and clear of the same register cancel to "set wins", so neither counts.
  assign w_set_eff = w_set && !r_busy[iss_rd];
  assign w_clr_eff = w_clr && r_busy[waddr] && !(w_set && (iss_rd == waddr));

  always_comb begin
    w_busy_d = r_busy;
    if (w_clr) begin
      w_busy_d[waddr] = 1'b0;
    end
    if (w_set) begin
      w_busy_d[iss_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_comb begin
    w_cnt_d = r_busy_cnt;
    if (w_set_eff && !w_clr_eff) begin
      w_cnt_d = r_busy_cnt + 1'b1;
    end else if (w_clr_eff && !w_set_eff) begin
      w_cnt_d = r_busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_cnt_d;
    end
  end

  for (genvar g = 0; g < int'(NREAD); g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;

    assign w_ra  = raddr[g*AW +: AW];
    assign w_hit = w_wr && (waddr == w_ra);

    always_comb begin
      if (w_ra == '0) begin
        rdata[g*XLEN +: XLEN] = '0;
      end else if (w_hit) begin
        rdata[g*XLEN +: XLEN] = wdata;
      end else begin
        rdata[g*XLEN +: XLEN] = r_regs[w_ra];
      end
    end

    // A source retiring this cycle is served by the bypass, not stalled.
    assign rbusy[g] = r_busy[w_ra] && !(w_hit && wb_clr);
  end

  assign stall    = |rbusy;
  assign busy_cnt = r_busy_cnt;
  assign dbg_out  = r_regs[DbgIdx];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset, x0, bypass, debug tap,
// scoreboard set/clear interactions and full fill/drain.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wb_clr;
  logic        iss_vld;
  logic [4:0]  iss_rd;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        stall;
  logic [5:0]  busy_cnt;
  logic [31:0] dbg_out;

  int n_cmp;
  int n_err;

  regfile_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wb_clr   (wb_clr),
    .iss_vld  (iss_vld),
    .iss_rd   (iss_rd),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .stall    (stall),
    .busy_cnt (busy_cnt),
    .dbg_out  (dbg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    wb_clr  = 1'b0;
    iss_vld = 1'b0;
    iss_rd  = '0;
    raddr   = '0;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
    rst_n = 1'b0;
    idle();
    step();
    step();
    #1;
    if (busy_cnt !== 6'd0) begin
      $display("FAIL reset_cnt got %0d want 0", busy_cnt); n_err++;
    end
    n_cmp++;
    if (dbg_out !== 32'd0) begin
      $display("FAIL reset_dbg got %h want 0", dbg_out); n_err++;
    end
    n_cmp++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      raddr = {addrs[i], addrs[i]};
      #1;
      if (rdata !== 64'd0 || stall !== 1'b0 || rbusy !== 2'b00) begin
        $display("FAIL reset_read a=%0d got rdata=%h stall=%b want 0/0", addrs[i], rdata, stall);
        n_err++;
      end
      n_cmp++;
    end
    step();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    #2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    raddr = {5'd5, 5'd5};
    #1;
    if (rdata !== 64'd0) begin
      $display("FAIL reset_midwrite got %h want 0", rdata); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_x0();
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    iss_vld = 1'b1; iss_rd = 5'd0;
    #1;
    if (rdata !== 64'd0) begin
      $display("FAIL x0_bypass got %h want 0", rdata); n_err++;
    end
    n_cmp++;
    step();
    idle();
    #1;
    if (rdata !== 64'd0) begin
      $display("FAIL x0_read got %h want 0", rdata); n_err++;
    end
    n_cmp++;
    if (busy_cnt !== 6'd0 || stall !== 1'b0) begin
      $display("FAIL x0_busy got cnt=%0d stall=%b want 0/0", busy_cnt, stall); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr = {5'd0, 5'd7};
    #1;
    if (rdata[31:0] !== 32'h12345678) begin
      $display("FAIL bypass0 got %h want 12345678", rdata[31:0]); n_err++;
    end
    n_cmp++;
    step();
    idle();
    raddr = {5'd7, 5'd0};
    #1;
    if (rdata[63:32] !== 32'h12345678) begin
      $display("FAIL stored1 got %h want 12345678", rdata[63:32]); n_err++;
    end
    n_cmp++;
    we = 1'b1; waddr = 5'd10; wdata = 32'hA5;
    #1;
    if (dbg_out !== 32'd0) begin
      $display("FAIL dbg_same_cycle got %h want 0", dbg_out); n_err++;
    end
    n_cmp++;
    step();
    idle();
    #1;
    if (dbg_out !== 32'hA5) begin
      $display("FAIL dbg_next_cycle got %h want a5", dbg_out); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_scoreboard();
    idle();
    iss_vld = 1'b1; iss_rd = 5'd3;
    step();
    idle();
    raddr = {5'd3, 5'd0};
    #1;
    if (rbusy !== 2'b10 || stall !== 1'b1 || busy_cnt !== 6'd1) begin
      $display("FAIL sb_issue got rbusy=%b stall=%b cnt=%0d want 10/1/1", rbusy, stall, busy_cnt);
      n_err++;
    end
    n_cmp++;
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    step();
    #1;
    if (rbusy !== 2'b10 || busy_cnt !== 6'd1) begin
      $display("FAIL sb_plain_write got rbusy=%b cnt=%0d want 10/1", rbusy, busy_cnt); n_err++;
    end
    n_cmp++;
    we = 1'b1; wb_clr = 1'b1; waddr = 5'd3; wdata = 32'h55;
    #1;
    if (rbusy !== 2'b00 || stall !== 1'b0 || rdata[63:32] !== 32'h55) begin
      $display("FAIL sb_retire got rbusy=%b stall=%b rdata1=%h want 00/0/55",
               rbusy, stall, rdata[63:32]);
      n_err++;
    end
    n_cmp++;
    step();
    idle();
    #1;
    if (busy_cnt !== 6'd0) begin
      $display("FAIL sb_cleared got %0d want 0", busy_cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_simultaneous();
    idle();
    iss_vld = 1'b1; iss_rd = 5'd9;
    step();
    iss_vld = 1'b1; iss_rd = 5'd9;
    we = 1'b1; wb_clr = 1'b1; waddr = 5'd9; wdata = 32'h99;
    step();
    idle();
    raddr = {5'd0, 5'd9};
    #1;
    if (rbusy !== 2'b01 || busy_cnt !== 6'd1) begin
      $display("FAIL same_reg got rbusy=%b cnt=%0d want 01/1", rbusy, busy_cnt); n_err++;
    end
    n_cmp++;
    iss_vld = 1'b1; iss_rd = 5'd4;
    we = 1'b1; wb_clr = 1'b1; waddr = 5'd9; wdata = 32'h9A;
    step();
    idle();
    raddr = {5'd4, 5'd9};
    #1;
    if (rbusy !== 2'b10 || busy_cnt !== 6'd1) begin
      $display("FAIL diff_reg got rbusy=%b cnt=%0d want 10/1", rbusy, busy_cnt); n_err++;
    end
    n_cmp++;
    we = 1'b1; wb_clr = 1'b1; waddr = 5'd12; wdata = 32'hC;
    step();
    idle();
    #1;
    if (busy_cnt !== 6'd1) begin
      $display("FAIL idle_clear got %0d want 1", busy_cnt); n_err++;
    end
    n_cmp++;
    we = 1'b1; wb_clr = 1'b1; waddr = 5'd4;
    step();
    idle();
    #1;
    if (busy_cnt !== 6'd0) begin
      $display("FAIL drain_x4 got %0d want 0", busy_cnt); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_fill();
    idle();
    for (int i = 1; i < 32; i++) begin
      iss_vld = 1'b1; iss_rd = 5'(i);
      step();
    end
    idle();
    raddr = {5'd31, 5'd1};
    #1;
    if (busy_cnt !== 6'd31 || rbusy !== 2'b11 || stall !== 1'b1) begin
      $display("FAIL fill got cnt=%0d rbusy=%b want 31/11", busy_cnt, rbusy); n_err++;
    end
    n_cmp++;
    iss_vld = 1'b1; iss_rd = 5'd1;
    step();
    idle();
    #1;
    if (busy_cnt !== 6'd31) begin
      $display("FAIL reissue got %0d want 31", busy_cnt); n_err++;
    end
    n_cmp++;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wb_clr = 1'b1; waddr = 5'(i); wdata = 32'(i);
      step();
    end
    idle();
    raddr = {5'd31, 5'd1};
    #1;
    if (busy_cnt !== 6'd0 || stall !== 1'b0) begin
      $display("FAIL drain got cnt=%0d stall=%b want 0/0", busy_cnt, stall); n_err++;
    end
    n_cmp++;
    if (rdata !== {32'd31, 32'd1}) begin
      $display("FAIL drain_data got %h want 0000001f00000001", rdata); n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
